clock_div_multi: RTL and testbench

//  Parametrised, multi-channel synchronous clock divider and tick generator.

---
 rtl/clock_div_pkg.sv | 12 +
 rtl/clock_div_chan.sv | 90 +++++++++
 rtl/clock_div_multi.sv | 53 +++++
 tb/tb_clock_div_multi.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   CNT_W_DEFAULT : default counter/divisor width in bits
//   DIV_HALT      : divisor value that stops a channel
//   div_t         : divisor/counter type at the default width
package clock_div_pkg;

  localparam int CNT_W_DEFAULT = 26;
  localparam int DIV_HALT      = 0;

  typedef logic [CNT_W_DEFAULT-1:0] div_t;

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: period counter, shadow/pending divisor, registered
// tick / square-wave / load-acknowledge outputs.
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   enable        in   count enable
//   sync_clr      in   synchronous phase clear
//   div_value     in   candidate divisor, captured on div_load
//   div_load      in   1-cycle strobe writing div_value into the shadow
//   load_ack      out  1-cycle pulse after the shadow became active
//   tick          out  1-cycle pulse once per divided period
//   new_frequency out  square wave, high ceil(D/2) / low floor(D/2) cycles
module clock_div_chan
  import clock_div_pkg::*;
#(
  parameter int               CNT_W     = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] RESET_DIV = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_clr,
  input  logic [CNT_W-1:0] div_value,
  input  logic             div_load,
  output logic             load_ack,
  output logic             tick,
  output logic             new_frequency
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] shadow_q;
  logic             pending_q;

  logic             halted;
  logic             wrap;
  logic             apply;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] half_up;

  assign halted   = (div_q == CNT_W'(DIV_HALT));
  assign wrap     = enable && !halted && (cnt_q == div_q - CNT_W'(1));
  assign cnt_next = wrap ? '0 : cnt_q + CNT_W'(1);

  // ceil(D/2) without widening: (2**W-1)>>1 plus one still fits in W bits.
  assign half_up  = (div_q >> 1) + CNT_W'(div_q[0]);

  // Divisor swaps only where the phase is already zero: at a wrap, on a
  // phase clear, or while halted (counter is parked at 0).
  assign apply    = pending_q && (sync_clr || halted || wrap);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      div_q         <= RESET_DIV;
      shadow_q      <= RESET_DIV;
      pending_q     <= 1'b0;
      load_ack      <= 1'b0;
      tick          <= 1'b0;
      new_frequency <= 1'b0;
    end else begin
      load_ack <= apply;

      if (apply) begin
        div_q     <= shadow_q;
        pending_q <= 1'b0;
      end

      // A load in the same cycle as an application re-arms pending, so the
      // fresh value waits for the next boundary.
      if (div_load) begin
        shadow_q  <= div_value;
        pending_q <= 1'b1;
      end

      if (sync_clr || halted) begin
        cnt_q         <= '0;
        tick          <= 1'b0;
        new_frequency <= 1'b0;
      end else if (enable) begin
        cnt_q         <= cnt_next;
        tick          <= wrap;
        new_frequency <= (cnt_next < half_up);
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_div_multi.sv
// Multi-channel synchronous clock divider / tick generator. Each channel has
// its own runtime divisor with boundary-aligned updates; sync_clr re-phases
// all channels together. No derived clocks leave the block.
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   enable        in   [NUM_CH]        per-channel count enable
//   sync_clr      in                   phase clear of all channels
//   div_value     in   [NUM_CH*CNT_W]  channel i divisor at [i*CNT_W +: CNT_W]
//   div_load      in   [NUM_CH]        per-channel shadow write strobe
//   load_ack      out  [NUM_CH]        shadow-became-active pulse
//   tick          out  [NUM_CH]        once-per-period pulse
//   new_frequency out  [NUM_CH]        divided square wave
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEFAULT,
  parameter int          NUM_CH      = 2,
  parameter int unsigned DEFAULT_DIV = 32'd67108864
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enable,
  input  logic                    sync_clr,
  input  logic [NUM_CH*CNT_W-1:0] div_value,
  input  logic [NUM_CH-1:0]       div_load,
  output logic [NUM_CH-1:0]       load_ack,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       new_frequency
);

  // Out-of-range defaults are truncated to CNT_W bits (2**26 becomes 0,
  // i.e. channels come out of reset halted until a divisor is loaded).
  localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clock_div_chan #(
      .CNT_W     (CNT_W),
      .RESET_DIV (RESET_DIV)
    ) u_chan (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable[i]),
      .sync_clr      (sync_clr),
      .div_value     (div_value[i*CNT_W +: CNT_W]),
      .div_load      (div_load[i]),
      .load_ack      (load_ack[i]),
      .tick          (tick[i]),
      .new_frequency (new_frequency[i])
    );
  end

endmodule

// File: tb/tb_clock_div_multi.sv
module tb_clock_div_multi;

  localparam int CNT_W  = 8;
  localparam int NUM_CH = 2;
  localparam int DEF    = 4;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       enable;
  logic                    sync_clr;
  logic [NUM_CH*CNT_W-1:0] div_value;
  logic [NUM_CH-1:0]       div_load;
  logic [NUM_CH-1:0]       load_ack;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       new_frequency;

  clock_div_multi #(
    .CNT_W       (CNT_W),
    .NUM_CH      (NUM_CH),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .sync_clr      (sync_clr),
    .div_value     (div_value),
    .div_load      (div_load),
    .load_ack      (load_ack),
    .tick          (tick),
    .new_frequency (new_frequency)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase position within the period, active/shadow divisor.
  int m_cnt  [NUM_CH];
  int m_d    [NUM_CH];
  int m_sh   [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_tick [NUM_CH];
  bit m_nf   [NUM_CH];
  bit m_ack  [NUM_CH];

  int ack_seen [NUM_CH];
  int coin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_cnt[ch] = 0; m_d[ch] = DEF; m_sh[ch] = DEF; m_pend[ch] = 0;
      m_tick[ch] = 0; m_nf[ch] = 0; m_ack[ch] = 0;
    end
  endfunction

  function automatic void take_shadow(input int ch);
    if (m_pend[ch]) begin
      m_d[ch] = m_sh[ch];
      m_pend[ch] = 0;
      m_ack[ch] = 1;
    end
  endfunction

  // One clock edge of the behavioural rules, using the inputs held at the edge.
  function automatic void model_step();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      int dv;
      int nxt;
      dv = int'(div_value[ch*CNT_W +: CNT_W]);
      m_ack[ch] = 0;
      if (sync_clr) begin
        m_cnt[ch] = 0; m_tick[ch] = 0; m_nf[ch] = 0;
        take_shadow(ch);
      end else if (m_d[ch] == 0) begin
        m_cnt[ch] = 0; m_tick[ch] = 0; m_nf[ch] = 0;
        take_shadow(ch);
      end else if (enable[ch]) begin
        nxt = (m_cnt[ch] + 1) % m_d[ch];
        m_tick[ch] = (nxt == 0);
        m_nf[ch]   = (nxt < (m_d[ch] + 1) / 2);
        m_cnt[ch]  = nxt;
        if (nxt == 0) take_shadow(ch);
      end else begin
        m_tick[ch] = 0;
      end
      if (div_load[ch]) begin
        m_sh[ch] = dv;
        m_pend[ch] = 1;
      end
    end
  endfunction

  task automatic compare_outputs();
    logic [NUM_CH-1:0] et, ef, ea;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      et[ch] = m_tick[ch];
      ef[ch] = m_nf[ch];
      ea[ch] = m_ack[ch];
    end
    check("tick", 32'(tick), 32'(et));
    check("new_frequency", 32'(new_frequency), 32'(ef));
    check("load_ack", 32'(load_ack), 32'(ea));
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    compare_outputs();
    for (int ch = 0; ch < NUM_CH; ch++) if (load_ack[ch]) ack_seen[ch]++;
    if (tick[0] && tick[1]) coin++;
    div_load = '0;
    sync_clr = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic load(input int ch, input int v);
    div_value[ch*CNT_W +: CNT_W] = CNT_W'(v);
    div_load[ch] = 1'b1;
  endtask

  task automatic wait_cnt(input int ch, input int target);
    int k = 0;
    while (m_cnt[ch] != target && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) check("wait_budget", 32'(k), 32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tick"}, 32'(tick), 32'(0));
    check({tag, "_nf"}, 32'(new_frequency), 32'(0));
    check({tag, "_ack"}, 32'(load_ack), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = '0; sync_clr = 1'b0; div_value = '0; div_load = '0;
    coin = 0;
    for (int ch = 0; ch < NUM_CH; ch++) ack_seen[ch] = 0;
    model_reset();
    #22;
    check_all_zero("reset");
    @(posedge clock); #1;
    reset = 1'b1;
    enable = '1;

    // default divisor 4
    run(12);

    // D=5, then D=1
    load(0, 5);
    run(15);
    load(0, 1);
    run(8);
    check("d1_tick", 32'(tick[0]), 32'(1));
    check("d1_nf", 32'(new_frequency[0]), 32'(1));

    // D=4, then load 6 mid-period
    load(0, 4);
    run(6);
    wait_cnt(0, 1);
    ack_seen[0] = 0;
    load(0, 6);
    run(2);
    check("mid_load_no_early_ack", 32'(ack_seen[0]), 32'(0));
    run(1);
    check("mid_load_ack", 32'(load_ack[0]), 32'(1));
    run(14);
    check("mid_load_single_ack", 32'(ack_seen[0]), 32'(1));

    // load at the wrap, overwritten before the next one
    wait_cnt(0, 5);
    ack_seen[0] = 0;
    load(0, 9);
    step();
    run(2);
    load(0, 7);
    run(20);
    check("repeat_load_single_ack", 32'(ack_seen[0]), 32'(1));

    // two channels, sync_clr realignment
    load(0, 3);
    load(1, 7);
    step();
    sync_clr = 1'b1;
    step();
    check("clr_apply_ack", 32'(load_ack), 32'(2'b11));
    run(5);
    sync_clr = 1'b1;
    step();
    coin = 0;
    run(42);
    check("coincident_ticks", 32'(coin), 32'(2));
    enable = 2'b01;
    run(10);
    enable = 2'b11;
    run(5);

    // halt with D=0, resume with D=8
    load(0, 0);
    run(5);
    check("halt_tick", 32'(tick[0]), 32'(0));
    check("halt_nf", 32'(new_frequency[0]), 32'(0));
    load(0, 8);
    step();
    step();
    check("resume_ack", 32'(load_ack[0]), 32'(1));
    run(12);

    // reset with a load pending
    load(1, 5);
    step();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all_zero("mid_reset");
    @(posedge clock); #1;
    reset = 1'b1;
    ack_seen[1] = 0;
    run(20);
    check("reset_drops_pending", 32'(ack_seen[1]), 32'(0));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        enable[ch] = ($urandom_range(9) != 0);
        if ($urandom_range(11) == 0) begin
          case ($urandom_range(9))
            0:       load(ch, 0);
            1:       load(ch, int'($urandom_range(255, 200)));
            default: load(ch, int'($urandom_range(12, 1)));
          endcase
        end
      end
      sync_clr = ($urandom_range(49) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
